// File: rtl/t05_histogram_rmw_if.sv
// Symbol handshake, controller status and bin SRAM port bundle for the histogram engine.
// The engine takes the slave modport; the producer/controller/SRAM side takes master.
interface t05_histogram_rmw_if #(
  parameter int SYM_W = 8,
  parameter int CNT_W = 32
);
  logic [SYM_W-1:0] sym_i;
  logic             sym_valid_i;
  logic             sym_ready_o;
  logic             clear_i;
  logic             sram_rd_en_o;
  logic             sram_wr_en_o;
  logic [SYM_W-1:0] sram_addr_o;
  logic [CNT_W-1:0] sram_rdata_i;
  logic [CNT_W-1:0] sram_wdata_o;
  logic [CNT_W-1:0] total_o;
  logic             eof_o;
  logic             complete_o;

  modport slave (
    input  sym_i, sym_valid_i, clear_i, sram_rdata_i,
    output sym_ready_o, sram_rd_en_o, sram_wr_en_o, sram_addr_o, sram_wdata_o,
           total_o, eof_o, complete_o
  );

  modport master (
    output sym_i, sym_valid_i, clear_i, sram_rdata_i,
    input  sym_ready_o, sram_rd_en_o, sram_wr_en_o, sram_addr_o, sram_wdata_o,
           total_o, eof_o, complete_o
  );
endinterface

// File: rtl/t05_histogram_rmw.sv
// Symbol histogram engine: per-symbol read-modify-write of an external bin SRAM, EOF detect, clear sweep.
// Latency: bin written 2 cycles after accept, 1 symbol per 3 cycles; clear sweep takes 2**SYM_W cycles.
// Backpressure: sym_ready_o only in IDLE without clear_i; HIST_SAT_EN selects saturating counters.
module t05_histogram_rmw #(
  parameter int               SYM_W   = 8,
  parameter int               CNT_W   = 32,
  parameter logic [SYM_W-1:0] EOF_SYM = 8'h1A
) (
  input logic                 clk,
  input logic                 rst,
  t05_histogram_rmw_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    CLEAR = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state;
  logic [SYM_W-1:0] sym_q;
  logic [SYM_W-1:0] sweep_q;
  logic [CNT_W-1:0] total_q;
  logic             eof_q;
  logic             complete_q;

  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] x);
`ifdef HIST_SAT_EN
    return (x == {CNT_W{1'b1}}) ? x : x + 1'b1;
`else
    return x + 1'b1;
`endif
  endfunction

  // Outputs are gated by rst so a WRITE interrupted by reset never reaches the SRAM.
  always_comb begin
    bus.sym_ready_o  = 1'b0;
    bus.sram_rd_en_o = 1'b0;
    bus.sram_wr_en_o = 1'b0;
    bus.sram_addr_o  = sym_q;
    bus.sram_wdata_o = '0;
    if (!rst) begin
      case (state)
        IDLE:  bus.sym_ready_o = !bus.clear_i;
        READ:  bus.sram_rd_en_o = 1'b1;
        WRITE: begin
          bus.sram_wr_en_o = 1'b1;
          bus.sram_wdata_o = inc(bus.sram_rdata_i);
        end
        CLEAR: begin
          bus.sram_wr_en_o = 1'b1;
          bus.sram_addr_o  = sweep_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sym_q      <= '0;
      sweep_q    <= '0;
      total_q    <= '0;
      eof_q      <= 1'b0;
      complete_q <= 1'b0;
    end else begin
      eof_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.clear_i) begin
            state      <= CLEAR;
            total_q    <= '0;
            complete_q <= 1'b0;
          end else if (bus.sym_valid_i) begin
            if (bus.sym_i != EOF_SYM) begin
              sym_q <= bus.sym_i;
              state <= READ;
            end else begin
              eof_q      <= 1'b1;
              complete_q <= 1'b1;
              state      <= DONE;
            end
          end
        end
        READ: state <= WRITE;
        WRITE: begin
          total_q <= inc(total_q);
          state   <= IDLE;
        end
        CLEAR: begin
          sweep_q <= sweep_q + 1'b1;
          if (sweep_q == {SYM_W{1'b1}}) state <= IDLE;
        end
        DONE: begin
          if (bus.clear_i) begin
            state      <= CLEAR;
            total_q    <= '0;
            complete_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.total_o    = total_q;
  assign bus.eof_o      = eof_q;
  assign bus.complete_o = complete_q;

endmodule

// File: tb/tb_t05_histogram_rmw.sv
// Bench for t05_histogram_rmw: SRAM model with write log, table vectors, corner sequences, random vs reference.
module tb_t05_histogram_rmw;

  localparam logic [7:0] EOF_SYM = 8'h1A;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  t05_histogram_rmw_if #(.SYM_W(8), .CNT_W(32)) bus();

  t05_histogram_rmw #(.SYM_W(8), .CNT_W(32), .EOF_SYM(EOF_SYM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic [31:0] mem [256];
  wr_t         wlog [$];
  int          cyc = 0;
  logic        pre_en = 1'b0;
  logic        pre_zero = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  // SRAM with one-cycle read latency; logs every write with the cycle it lands.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.sram_rd_en_o) bus.sram_rdata_i <= mem[bus.sram_addr_o];
    if (bus.sram_wr_en_o) begin
      mem[bus.sram_addr_o] <= bus.sram_wdata_o;
      wlog.push_back('{cyc, bus.sram_addr_o, bus.sram_wdata_o});
    end
    if (pre_zero) for (int i = 0; i < 256; i++) mem[i] <= '0;
    if (pre_en) mem[pre_addr] <= pre_data;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Spec-level increment: add one, then either clamp at all-ones or keep the low 32 bits.
  function automatic logic [31:0] ref_inc(input logic [31:0] x);
    longint v;
    v = longint'(x) + 64'd1;
`ifdef HIST_SAT_EN
    if (v > 64'h0000_0000_FFFF_FFFF) v = 64'h0000_0000_FFFF_FFFF;
`endif
    return v[31:0];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.sym_valid_i = 1'b0;
    bus.clear_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic zero_mem();
    @(negedge clk); pre_zero = 1'b1;
    @(negedge clk); pre_zero = 1'b0;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk); pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk); pre_en = 1'b0;
  endtask

  task automatic send(input logic [7:0] s, output int acc_cyc);
    int n;
    n = 0;
    @(negedge clk);
    bus.sym_i = s;
    bus.sym_valid_i = 1'b1;
    #1;
    while (!bus.sym_ready_o && n < 400) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 400) timeout("send_ready");
    acc_cyc = cyc;
    @(negedge clk);
    bus.sym_valid_i = 1'b0;
    #1;
  endtask

  task automatic wait_ready(input int bound);
    int n;
    n = 0;
    #1;
    while (!bus.sym_ready_o && n < bound) begin
      @(negedge clk); #1; n++;
    end
    if (n >= bound) timeout("wait_ready");
  endtask

  task automatic pulse_clear();
    @(negedge clk); bus.clear_i = 1'b1;
    @(negedge clk); bus.clear_i = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  sym;
    logic [31:0] pre;
    logic [31:0] exp_bin;
    logic [31:0] exp_tot;
  } vec_t;

  vec_t        tbl [5];
  logic [31:0] ref_bin [256];
  logic [31:0] ref_total;

  initial begin
    int          a0, base, bad, first;
    logic [7:0]  ea [3];
    logic [31:0] ed [3];
    int          ac [3];
    logic [31:0] wrap_exp;
    logic [7:0]  s;
    int          r;

    bus.sym_i = '0;
    bus.sym_valid_i = 1'b0;
    bus.clear_i = 1'b0;
    bus.sram_rdata_i = '0;

    // Reset state, then three symbols with a repeat
    do_reset();
    #1;
    chk("rst_ready", bus.sym_ready_o, 1);
    chk("rst_rd_en", bus.sram_rd_en_o, 0);
    chk("rst_wr_en", bus.sram_wr_en_o, 0);
    chk("rst_total", bus.total_o, 0);
    chk("rst_eof", bus.eof_o, 0);
    chk("rst_complete", bus.complete_o, 0);
    zero_mem();
    base = wlog.size();
    ea[0] = 8'h41; ea[1] = 8'h42; ea[2] = 8'h41;
    ed[0] = 1;     ed[1] = 1;     ed[2] = 2;
    for (int i = 0; i < 3; i++) send(ea[i], ac[i]);
    wait_ready(20);
    chk("t1_nwrites", wlog.size() - base, 3);
    for (int i = 0; i < 3 && base + i < wlog.size(); i++) begin
      chk("t1_waddr", wlog[base+i].addr, ea[i]);
      chk("t1_wdata", wlog[base+i].data, ed[i]);
      chk("t1_wcycle", wlog[base+i].cyc, ac[i] + 2);
    end
    chk("t1_bin41", mem[8'h41], 2);
    chk("t1_bin42", mem[8'h42], 1);
    chk("t1_total", bus.total_o, 3);

    // EOF handling
    do_reset();
    preload(EOF_SYM, 32'h55);
    send(8'h41, a0);
    wait_ready(20);
    base = wlog.size();
    send(EOF_SYM, a0);
    chk("t2_eof_first", bus.eof_o, 1);
    chk("t2_complete", bus.complete_o, 1);
    chk("t2_ready_done", bus.sym_ready_o, 0);
    @(negedge clk); #1;
    chk("t2_eof_second", bus.eof_o, 0);
    chk("t2_complete_hold", bus.complete_o, 1);
    chk("t2_total", bus.total_o, 1);
    chk("t2_bin1a", mem[EOF_SYM], 32'h55);
    chk("t2_no_writes", wlog.size() - base, 0);

    // Clear sweep from DONE
    base = wlog.size();
    pulse_clear();
    #1;
    chk("t3_complete_drop", bus.complete_o, 0);
    chk("t3_total_zero", bus.total_o, 0);
    chk("t3_ready_clear", bus.sym_ready_o, 0);
    wait_ready(300);
    chk("t3_nwrites", wlog.size() - base, 256);
    bad = 0;
    first = (wlog.size() > base) ? wlog[base].cyc : 0;
    for (int i = 0; i < 256 && base + i < wlog.size(); i++)
      if (wlog[base+i].addr != i[7:0] || wlog[base+i].data != 0 || wlog[base+i].cyc != first + i) bad++;
    chk("t3_sweep_order", bad, 0);
    chk("t3_ready_after", bus.sym_ready_o, 1);

    // Table vectors: preload, single symbol, check bin, write timing and total
`ifdef HIST_SAT_EN
    wrap_exp = 32'hFFFF_FFFF;
`else
    wrap_exp = 32'h0;
`endif
    tbl[0] = '{8'h10, 32'hFFFF_FFFF, wrap_exp,     32'd1};
    tbl[1] = '{8'h41, 32'h0,         32'h1,        32'd2};
    tbl[2] = '{8'h42, 32'h7,         32'h8,        32'd3};
    tbl[3] = '{8'hFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd4};
    tbl[4] = '{8'h00, 32'h1234,      32'h1235,     32'd5};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      preload(tbl[i].sym, tbl[i].pre);
      base = wlog.size();
      send(tbl[i].sym, a0);
      wait_ready(20);
      chk("tbl_nwrites", wlog.size() - base, 1);
      if (wlog.size() > base) begin
        chk("tbl_wdata", wlog[base].data, tbl[i].exp_bin);
        chk("tbl_wcycle", wlog[base].cyc, a0 + 2);
      end
      chk("tbl_bin", mem[tbl[i].sym], tbl[i].exp_bin);
      chk("tbl_total", bus.total_o, tbl[i].exp_tot);
    end

    // Reset during the WRITE cycle
    do_reset();
    preload(8'h20, 32'd5);
    base = wlog.size();
    send(8'h20, a0);
    @(negedge clk); #1;
    chk("t5_in_write", bus.sram_wr_en_o, 1);
    rst = 1'b1;
    #1;
    chk("t5_wr_gated", bus.sram_wr_en_o, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t5_ready", bus.sym_ready_o, 1);
    chk("t5_wr_after", bus.sram_wr_en_o, 0);
    chk("t5_total", bus.total_o, 0);
    chk("t5_bin20", mem[8'h20], 5);
    chk("t5_no_writes", wlog.size() - base, 0);

    // clear_i and a symbol together in IDLE
    preload(8'h30, 32'd9);
    base = wlog.size();
    @(negedge clk);
    bus.clear_i = 1'b1; bus.sym_valid_i = 1'b1; bus.sym_i = 8'h30;
    #1;
    chk("t6_ready_low", bus.sym_ready_o, 0);
    @(negedge clk);
    bus.clear_i = 1'b0; bus.sym_valid_i = 1'b0;
    #1;
    chk("t6_sweep_wr", bus.sram_wr_en_o, 1);
    chk("t6_sweep_addr0", bus.sram_addr_o, 0);
    wait_ready(300);
    chk("t6_nwrites", wlog.size() - base, 256);
    chk("t6_bin30", mem[8'h30], 0);
    chk("t6_total", bus.total_o, 0);

    // Randomized traffic against the reference histogram
    do_reset();
    zero_mem();
    for (int i = 0; i < 256; i++) ref_bin[i] = '0;
    ref_total = '0;
    for (int k = 0; k < 3; k++) begin
      s = 8'(8'h50 + k);
      preload(s, 32'hFFFF_FFFE);
      ref_bin[s] = 32'hFFFF_FFFE;
    end
    for (int op = 0; op < 160; op++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        pulse_clear();
        wait_ready(300);
        for (int i = 0; i < 256; i++) ref_bin[i] = '0;
        ref_total = '0;
      end else if (r < 7) begin
        send(EOF_SYM, a0);
        chk("rnd_eof", bus.eof_o, 1);
        chk("rnd_complete", bus.complete_o, 1);
        pulse_clear();
        wait_ready(300);
        for (int i = 0; i < 256; i++) ref_bin[i] = '0;
        ref_total = '0;
      end else begin
        if (r < 55) s = 8'($urandom_range(8'h50, 8'h53));
        else        s = 8'($urandom_range(0, 255));
        if (s == EOF_SYM) s = 8'h1B;
        send(s, a0);
        ref_bin[s] = ref_inc(ref_bin[s]);
        ref_total = ref_inc(ref_total);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        wait_ready(20);
      end
      chk("rnd_total", bus.total_o, ref_total);
    end
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_bin[i]) bad++;
    chk("rnd_bins", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
